// File: rtl/shift_pkg.sv
// Shared constants for the shift sequencer: operand width, shift-mode codes
// and the sequencer's FSM state encoding.
package shift_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  localparam logic [2:0] SHL = 3'd0;
  localparam logic [2:0] SHR = 3'd1;
  localparam logic [2:0] ROL = 3'd2;
  localparam logic [2:0] ROR = 3'd3;
  localparam logic [2:0] ASR = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_sequencer_shift.sv
// Single-step shift/rotate unit: one bit position per evaluation.
// Codes outside the defined modes pass the operand and carry through unchanged.
module shift
  import shift_pkg::*;
#(
  parameter int WIDTH = shift_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] in,
  input  logic             cin,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             cout
);

  // One-step datapath selected by mode
  always_comb begin
    out  = in;
    cout = cin;
    case (mode)
      SHL: begin
        out  = {in[WIDTH-2:0], cin};
        cout = in[WIDTH-1];
      end
      SHR: begin
        out  = {cin, in[WIDTH-1:1]};
        cout = in[0];
      end
      ROL: begin
        out  = {in[WIDTH-2:0], in[WIDTH-1]};
        cout = in[WIDTH-1];
      end
      ROR: begin
        out  = {in[0], in[WIDTH-1:1]};
        cout = in[0];
      end
      ASR: begin
        out  = {in[WIDTH-1], in[WIDTH-1:1]};
        cout = in[0];
      end
      default: begin
        out  = in;
        cout = cin;
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: steps the single-bit shift unit once per clock,
// chaining carry between steps, with a start/busy/done handshake.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = shift_pkg::WIDTH,
  parameter int CNT_W = shift_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             carry_in,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cy_q, cy_d;
  logic [2:0]       mode_q, mode_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  logic [WIDTH-1:0] sh_out;
  logic             sh_cout;

  shift #(.WIDTH(WIDTH)) u_shift (
    .in   (acc_q),
    .cin  (cy_q),
    .mode (mode_q),
    .out  (sh_out),
    .cout (sh_cout)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cy_q    <= 1'b0;
      mode_q  <= 3'd0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cy_q    <= cy_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE and DONE
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cy_d    = cy_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          acc_d   = data_in;
          cy_d    = carry_in;
          mode_d  = mode;
          rem_d   = count;
          state_d = (count != '0) ? RUN : DONE;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = sh_out;
        cy_d  = sh_cout;
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign result    = acc_q;
  assign carry_out = cy_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed table, hand-written
// corner sequences and randomized operations against a behavioural model.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data_in;
  logic       carry_in;
  logic [2:0] mode;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       carry_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .carry_in  (carry_in),
    .mode      (mode),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
  );

  typedef struct {
    logic [2:0] m;
    logic [7:0] d;
    logic       c;
    logic [3:0] n;
    logic [7:0] er;
    logic       ec;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: apply n single steps using integer arithmetic.
  function automatic logic [8:0] ref_op(input logic [2:0] m, input logic [7:0] d,
                                        input logic c, input logic [3:0] n);
    int v, cy, nv, ncy;
    v  = d;
    cy = c;
    for (int i = 0; i < n; i++) begin
      case (m)
        3'd0: begin nv = ((v * 2) + cy) % 256;           ncy = v / 128; end
        3'd1: begin nv = (v / 2) + cy * 128;             ncy = v % 2;   end
        3'd2: begin nv = ((v * 2) % 256) + v / 128;      ncy = v / 128; end
        3'd3: begin nv = (v / 2) + (v % 2) * 128;        ncy = v % 2;   end
        3'd4: begin nv = (v / 2) + (v / 128) * 128;      ncy = v % 2;   end
        default: begin nv = v; ncy = cy; end
      endcase
      v  = nv;
      cy = ncy;
    end
    return {cy[0], v[7:0]};
  endfunction

  // Full operation with cycle-exact handshake checks; cycle 0 is the start cycle.
  task automatic run_op(input logic [2:0] m, input logic [7:0] d, input logic c,
                        input logic [3:0] n, input logic [7:0] er, input logic ec);
    @(negedge clk);
    start = 1'b1; mode = m; data_in = d; carry_in = c; count = n;
    @(negedge clk);
    start = 1'b0;
    data_in = 8'($urandom); mode = 3'($urandom); carry_in = 1'($urandom); count = 4'($urandom);
    for (int k = 1; k <= n; k++) begin
      chk("busy_run", busy, 1);
      chk("done_early", done, 0);
      @(negedge clk);
    end
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 0);
    chk("result", result, er);
    chk("carry_out", carry_out, ec);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("result_hold", result, er);
    chk("carry_hold", carry_out, ec);
  endtask

  vec_t vt[5];
  logic [8:0] r;

  initial begin
    rst = 1'b1; start = 1'b0; data_in = 8'h00; carry_in = 1'b0; mode = 3'd0; count = 4'd0;
    vt[0] = '{3'd0, 8'hAA, 1'b0, 4'd1, 8'h54, 1'b1};
    vt[1] = '{3'd0, 8'hAA, 1'b0, 4'd3, 8'h52, 1'b1};
    vt[2] = '{3'd3, 8'hAA, 1'b0, 4'd4, 8'hAA, 1'b1};
    vt[3] = '{3'd4, 8'h80, 1'b0, 4'd7, 8'hFF, 1'b0};
    vt[4] = '{3'd0, 8'h3C, 1'b1, 4'd0, 8'h3C, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 8'h00);
    chk("rst_carry", carry_out, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++)
      run_op(vt[i].m, vt[i].d, vt[i].c, vt[i].n, vt[i].er, vt[i].ec);

    // Reserved mode passes operand and carry through unchanged
    run_op(3'd6, 8'h5A, 1'b1, 4'd15, 8'h5A, 1'b1);

    // ROL 0x81 x5 with an ignored start mid-run, then back-to-back start in DONE
    @(negedge clk);
    start = 1'b1; mode = 3'd2; data_in = 8'h81; carry_in = 1'b0; count = 4'd5;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    start = 1'b1; data_in = 8'hFF; mode = 3'd0; carry_in = 1'b1; count = 4'd1;
    @(negedge clk); start = 1'b0;
    chk("ignore_busy", busy, 1);
    repeat (3) @(negedge clk);
    chk("ignore_done", done, 1);
    chk("ignore_result", result, 8'h30);
    chk("ignore_carry", carry_out, 0);
    start = 1'b1; mode = 3'd1; data_in = 8'h0F; carry_in = 1'b1; count = 4'd2;
    @(negedge clk); start = 1'b0;
    chk("b2b_busy1", busy, 1);
    chk("b2b_done_low", done, 0);
    @(negedge clk);
    chk("b2b_busy2", busy, 1);
    @(negedge clk);
    chk("b2b_done", done, 1);
    chk("b2b_result", result, 8'hC3);
    chk("b2b_carry", carry_out, 1);

    // Reset in cycle 2 of a count=6 operation aborts with no done pulse
    @(negedge clk);
    start = 1'b1; mode = 3'd0; data_in = 8'hF0; carry_in = 1'b1; count = 4'd6;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 8'h00);
    chk("abort_carry", carry_out, 0);
    for (int k = 0; k < 10; k++) begin
      chk("abort_no_done", done, 0);
      @(negedge clk);
    end

    // Reset wins over start in the same cycle
    start = 1'b1; rst = 1'b1; count = 4'd3; data_in = 8'h11;
    @(negedge clk); start = 1'b0; rst = 1'b0;
    chk("rst_prio_busy", busy, 0);
    chk("rst_prio_done", done, 0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] m;
      logic [7:0] d;
      logic       c;
      logic [3:0] n;
      m = 3'($urandom_range(0, 7));
      d = 8'($urandom);
      c = 1'($urandom);
      n = 4'($urandom_range(0, 15));
      r = ref_op(m, d, c, n);
      run_op(m, d, c, n, r[7:0], r[8]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
